sram_bus_arbiter: RTL and testbench
===================================

// Module: sram_bus_arbiter
// PURPOSE
//  Shares one SRAM-like memory bus between the fetch port (IF) and the load/store port (MEM).
//  Carries one outstanding transaction at a time and returns one-cycle done pulses.
//  The hazard unit derives stallF/stallM from req & ~done. Sits between the datapath and the bus bridge.
// PARAMETERS
//  AW           32  address width
//  DW           32  data width (byte enables = DW/8)
//  STARVE_LIMIT 4   consecutive data grants before fetch is forced (only with ARB_STARVE_GUARD_EN)
// PORTS
//  clk          in   1      clock; all state on rising edge
//  rst          in   1      synchronous, active-high reset
//  inst_req     in   1      fetch request; held until inst_done
//  inst_addr    in   AW     fetch address; stable while inst_req
//  inst_rdata   out  DW     fetched word; valid when inst_done
//  inst_done    out  1      one-cycle completion pulse, fetch
//  data_req     in   1      load/store request; held until data_done
//  data_wr      in   1      1 = store, 0 = load
//  data_be      in   DW/8   byte enables (store)
//  data_addr    in   AW     load/store address
//  data_wdata   in   DW     store data
//  data_rdata   out  DW     load data; valid when data_done
//  data_done    out  1      one-cycle completion pulse, load/store
//  bus_req      out  1      bus request; held until bus_addr_ok
//  bus_wr       out  1      bus write
//  bus_be       out  DW/8   bus byte enables (all ones for fetch)
//  bus_addr     out  AW     bus address
//  bus_wdata    out  DW     bus write data
//  bus_addr_ok  in   1      slave accepted address
//  bus_data_ok  in   1      slave returned data / write ack
//  bus_rdata    in   DW     bus read data; valid with bus_data_ok
// BEHAVIOUR
//  - FSM states:
//    IDLE --any req--> ADDR
//    ADDR --addr_ok & ~data_ok--> DATA
//    ADDR --addr_ok & data_ok--> DONE
//    DATA --data_ok--> DONE
//    DONE --> IDLE (always; one cycle)
//  - Grant in IDLE: data_req wins over inst_req (MEM instruction is older).
//    Owner, addr, wr, be and wdata are latched into registers on the IDLE->ADDR edge.
//    Requester inputs are ignored after the latch.
//  - bus_req = (state==ADDR). Bus outputs come from the latched registers and are 0 in IDLE/DONE.
//    A fetch drives bus_wr=0 and bus_be=all ones.
//  - The rdata register captures bus_rdata on data_ok. In DONE, only the owner's done pulses for 1 cycle.
//    inst_rdata and data_rdata both show the register. A load is zero-extended; the datapath sign-extends.
//  - Minimum latency req->done is 3 cycles (IDLE, ADDR with addr_ok&data_ok, DONE).
//  - DONE ignores requests, so a still-high req after done is treated as new and sampled in the next IDLE.
//    Back-to-back fetches therefore cost 1 bubble.
//  - bus_data_ok outside ADDR/DATA is ignored. bus_addr_ok outside ADDR is ignored.
//  - Reset (any state): state=IDLE; all outputs, latched registers and the starve counter = 0.
//    An in-flight bus transaction is abandoned, and the bridge is reset with the same rst.
// CONFIGURATION
//  - ARB_STARVE_GUARD_EN defined:
//    - A counter increments on each data grant while inst_req is high.
//    - It clears on any fetch grant, and clears on a data grant with inst_req low.
//    - When count==STARVE_LIMIT and both reqs are high, fetch wins.
//  - ARB_STARVE_GUARD_EN undefined: strict data priority; no counter logic.
// STRUCTURE
//  - defines2.vh gets the constants: state encodings ARB_IDLE/ARB_ADDR/ARB_DATA/ARB_DONE (2b) and owner codes ARB_OWN_INST/ARB_OWN_DATA.
//  - One sub-module, arb_starve_cnt: the saturating grant counter with a force_inst output.
//    It is instantiated only under ARB_STARVE_GUARD_EN.
//  - The FSM and latch registers stay in this module.
// TESTING
//  - Fetch alone, inst_addr=0xBFC00000:
//    - Expect bus_req for 1 cycle with addr 0xBFC00000, wr=0, be=4'hF.
//    - Slave gives addr_ok+data_ok same cycle, rdata=0x24080001.
//    - Next cycle: inst_done=1 and inst_rdata=0x24080001, then IDLE.
//  - inst_req and data_req rise together, store addr 0x80001000, be=4'b0011, wdata=0xDEADBEEF:
//    - The data transaction goes first with bus_wr=1, be=0011.
//    - data_done pulses before fetch starts; fetch is granted in the following IDLE.
//  - Slave delays addr_ok 3 cycles, then data_ok 2 cycles later:
//    - bus_req stays high and bus_addr stable for 3 cycles.
//    - The done pulse comes exactly 1 cycle after data_ok.
//  - rst asserted while in DATA:
//    - Next cycle all outputs are 0 and state is IDLE.
//    - A late bus_data_ok produces no done pulse.
//  - ARB_STARVE_GUARD_EN, STARVE_LIMIT=4, both reqs held high:
//    - Expect grant order D,D,D,D,I,D...
//    - Without the macro, only D until data_req drops.
//  - Back-to-back fetches with inst_req held: there is exactly 1 idle cycle between done and the next bus_req.

Source files
------------

// File: rtl/sram_bus_arbiter_pkg.sv
// Shared constants for the SRAM bus arbiter: FSM state encodings and owner codes.
package sram_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2,
        ARB_DONE = 2'd3
    } arb_state_t;

    typedef enum logic {
        ARB_OWN_INST = 1'b0,
        ARB_OWN_DATA = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/sram_bus_arbiter_starve_cnt.sv
// arb_starve_cnt: saturating count of consecutive data grants made while a
// fetch was waiting. force_inst tells the arbiter to let the fetch through.
module arb_starve_cnt #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic grant_data,
    input  logic grant_inst,
    input  logic inst_req,
    output logic force_inst
);

    // One spare bit of headroom so a limit of 0 still gets a legal width.
    localparam int CW = $clog2(STARVE_LIMIT + 2);
    localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

    logic [CW-1:0] cnt_reg;

    // Count data grants that overtook a waiting fetch; any fetch grant or an uncontested data grant restarts.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (grant_inst) begin
            cnt_reg <= '0;
        end else if (grant_data) begin
            if (!inst_req) begin
                cnt_reg <= '0;
            end else if (cnt_reg != LIMIT_C) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign force_inst = (cnt_reg == LIMIT_C);

endmodule

// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: shares one SRAM-like bus between the fetch (inst) and the
// load/store (data) ports, one outstanding transaction at a time.
// Optional fetch starvation guard: define ARB_STARVE_GUARD_EN.
module sram_bus_arbiter
    import sram_bus_arbiter_pkg::*;
#(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inst_req,
    input  logic [AW-1:0]   inst_addr,
    output logic [DW-1:0]   inst_rdata,
    output logic            inst_done,
    input  logic            data_req,
    input  logic            data_wr,
    input  logic [DW/8-1:0] data_be,
    input  logic [AW-1:0]   data_addr,
    input  logic [DW-1:0]   data_wdata,
    output logic [DW-1:0]   data_rdata,
    output logic            data_done,
    output logic            bus_req,
    output logic            bus_wr,
    output logic [DW/8-1:0] bus_be,
    output logic [AW-1:0]   bus_addr,
    output logic [DW-1:0]   bus_wdata,
    input  logic            bus_addr_ok,
    input  logic            bus_data_ok,
    input  logic [DW-1:0]   bus_rdata
);

    arb_state_t        state_reg, state_next;
    arb_owner_t        owner_reg;
    logic [AW-1:0]     addr_reg;
    logic              wr_reg;
    logic [DW/8-1:0]   be_reg;
    logic [DW-1:0]     wdata_reg;
    logic [DW-1:0]     rdata_reg;

    logic              force_inst;
    logic              grant_inst;
    logic              grant_data;
    logic              capture_rdata;

`ifdef ARB_STARVE_GUARD_EN
    arb_starve_cnt #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk        (clk),
        .rst        (rst),
        .grant_data (grant_data),
        .grant_inst (grant_inst),
        .inst_req   (inst_req),
        .force_inst (force_inst)
    );
`else
    // Strict data priority; the limit only matters with the guard, so this is constant 0.
    assign force_inst = (STARVE_LIMIT < 0);
`endif

    // Data (older instruction) wins in IDLE unless the starvation guard forces the fetch.
    assign grant_inst = (state_reg == ARB_IDLE) && inst_req && (!data_req || force_inst);
    assign grant_data = (state_reg == ARB_IDLE) && data_req && !grant_inst;

    assign capture_rdata = ((state_reg == ARB_ADDR) && bus_addr_ok && bus_data_ok) ||
                           ((state_reg == ARB_DATA) && bus_data_ok);

    // Next-state logic for the single-outstanding bus handshake.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ARB_IDLE: if (grant_inst || grant_data) state_next = ARB_ADDR;
            ARB_ADDR: if (bus_addr_ok) state_next = bus_data_ok ? ARB_DONE : ARB_DATA;
            ARB_DATA: if (bus_data_ok) state_next = ARB_DONE;
            ARB_DONE: state_next = ARB_IDLE;
            default:  state_next = ARB_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ARB_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Latch the winning request on the grant edge; requester inputs are ignored afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_reg <= ARB_OWN_INST;
            addr_reg  <= '0;
            wr_reg    <= 1'b0;
            be_reg    <= '0;
            wdata_reg <= '0;
        end else if (grant_data) begin
            owner_reg <= ARB_OWN_DATA;
            addr_reg  <= data_addr;
            wr_reg    <= data_wr;
            be_reg    <= data_be;
            wdata_reg <= data_wdata;
        end else if (grant_inst) begin
            owner_reg <= ARB_OWN_INST;
            addr_reg  <= inst_addr;
            wr_reg    <= 1'b0;
            be_reg    <= '1;
            wdata_reg <= '0;
        end
    end

    // Read data is held from data_ok until the next completed transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_reg <= '0;
        end else if (capture_rdata) begin
            rdata_reg <= bus_rdata;
        end
    end

    // Bus and completion outputs decoded from state; bus fields are zero outside ADDR/DATA.
    always_comb begin
        bus_req   = 1'b0;
        bus_wr    = 1'b0;
        bus_be    = '0;
        bus_addr  = '0;
        bus_wdata = '0;
        inst_done = 1'b0;
        data_done = 1'b0;
        if (state_reg == ARB_ADDR || state_reg == ARB_DATA) begin
            bus_wr    = wr_reg;
            bus_be    = be_reg;
            bus_addr  = addr_reg;
            bus_wdata = wdata_reg;
        end
        if (state_reg == ARB_ADDR) begin
            bus_req = 1'b1;
        end
        if (state_reg == ARB_DONE) begin
            inst_done = (owner_reg == ARB_OWN_INST);
            data_done = (owner_reg == ARB_OWN_DATA);
        end
    end

    assign inst_rdata = rdata_reg;
    assign data_rdata = rdata_reg;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Testbench for sram_bus_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of the arbiter's rules.
module tb_sram_bus_arbiter;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int BW    = DW / 8;
    localparam int LIMIT = 4;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          inst_req;
    logic [AW-1:0] inst_addr;
    logic [DW-1:0] inst_rdata;
    logic          inst_done;
    logic          data_req;
    logic          data_wr;
    logic [BW-1:0] data_be;
    logic [AW-1:0] data_addr;
    logic [DW-1:0] data_wdata;
    logic [DW-1:0] data_rdata;
    logic          data_done;
    logic          bus_req;
    logic          bus_wr;
    logic [BW-1:0] bus_be;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic          bus_addr_ok;
    logic          bus_data_ok;
    logic [DW-1:0] bus_rdata;

    int pass_cnt  = 0;
    int total_cnt = 0;

    sram_bus_arbiter #(
        .AW           (AW),
        .DW           (DW),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .inst_req    (inst_req),
        .inst_addr   (inst_addr),
        .inst_rdata  (inst_rdata),
        .inst_done   (inst_done),
        .data_req    (data_req),
        .data_wr     (data_wr),
        .data_be     (data_be),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_rdata  (data_rdata),
        .data_done   (data_done),
        .bus_req     (bus_req),
        .bus_wr      (bus_wr),
        .bus_be      (bus_be),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_addr_ok (bus_addr_ok),
        .bus_data_ok (bus_data_ok),
        .bus_rdata   (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        inst_req    = 1'b0;
        inst_addr   = '0;
        data_req    = 1'b0;
        data_wr     = 1'b0;
        data_be     = '0;
        data_addr   = '0;
        data_wdata  = '0;
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        bus_rdata   = '0;
    endtask

    task automatic do_reset;
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        total_cnt++;
        if ({bus_req, bus_wr, bus_be} !== '0) $display("FAIL reset_bus_ctl: got %b required 0", {bus_req, bus_wr, bus_be});
        else pass_cnt++;
        total_cnt++;
        if ({bus_addr, bus_wdata} !== '0) $display("FAIL reset_bus_data: got %h required 0", {bus_addr, bus_wdata});
        else pass_cnt++;
        total_cnt++;
        if ({inst_done, data_done, inst_rdata, data_rdata} !== '0) $display("FAIL reset_done_rdata: got %h required 0", {inst_done, data_done, inst_rdata, data_rdata});
        else pass_cnt++;
        $display("test_reset: outputs after reset checked");
    endtask

    task automatic test_fetch_alone;
        do_reset();
        inst_req  = 1'b1;
        inst_addr = 32'hBFC0_0000;
        step();
        total_cnt++;
        if ({bus_req, bus_wr, bus_be, bus_addr} !== {1'b1, 1'b0, 4'hF, 32'hBFC0_0000}) $display("FAIL fetch_addr_phase: got req=%b wr=%b be=%h addr=%h required 1 0 f bfc00000", bus_req, bus_wr, bus_be, bus_addr);
        else pass_cnt++;
        bus_addr_ok = 1'b1;
        bus_data_ok = 1'b1;
        bus_rdata   = 32'h2408_0001;
        step();
        total_cnt++;
        if ({inst_done, data_done, bus_req, inst_rdata} !== {1'b1, 1'b0, 1'b0, 32'h2408_0001}) $display("FAIL fetch_done: got idone=%b ddone=%b req=%b rdata=%h required 1 0 0 24080001", inst_done, data_done, bus_req, inst_rdata);
        else pass_cnt++;
        clear_inputs();
        step();
        total_cnt++;
        if ({inst_done, bus_req} !== 2'b00) $display("FAIL fetch_idle_after: got idone=%b req=%b required 0 0", inst_done, bus_req);
        else pass_cnt++;
        $display("test_fetch_alone: single fetch transaction checked");
    endtask

    task automatic test_simultaneous;
        do_reset();
        inst_req   = 1'b1;
        inst_addr  = 32'hBFC0_0000;
        data_req   = 1'b1;
        data_wr    = 1'b1;
        data_addr  = 32'h8000_1000;
        data_be    = 4'b0011;
        data_wdata = 32'hDEAD_BEEF;
        step();
        total_cnt++;
        if ({bus_req, bus_wr, bus_be, bus_addr, bus_wdata} !== {1'b1, 1'b1, 4'b0011, 32'h8000_1000, 32'hDEAD_BEEF}) $display("FAIL simul_store_first: got req=%b wr=%b be=%b addr=%h wdata=%h required 1 1 0011 80001000 deadbeef", bus_req, bus_wr, bus_be, bus_addr, bus_wdata);
        else pass_cnt++;
        bus_addr_ok = 1'b1;
        bus_data_ok = 1'b1;
        step();
        total_cnt++;
        if ({data_done, inst_done} !== 2'b10) $display("FAIL simul_data_done: got ddone=%b idone=%b required 1 0", data_done, inst_done);
        else pass_cnt++;
        data_req = 1'b0;
        step();
        total_cnt++;
        if ({bus_req, inst_done, data_done} !== 3'b000) $display("FAIL simul_bubble: got req=%b idone=%b ddone=%b required 0 0 0", bus_req, inst_done, data_done);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({bus_req, bus_wr, bus_be, bus_addr} !== {1'b1, 1'b0, 4'hF, 32'hBFC0_0000}) $display("FAIL simul_fetch_second: got req=%b wr=%b be=%h addr=%h required 1 0 f bfc00000", bus_req, bus_wr, bus_be, bus_addr);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({inst_done, data_done} !== 2'b10) $display("FAIL simul_inst_done: got idone=%b ddone=%b required 1 0", inst_done, data_done);
        else pass_cnt++;
        clear_inputs();
        $display("test_simultaneous: store then fetch ordering checked");
    endtask

    task automatic test_delayed_slave;
        do_reset();
        inst_req  = 1'b1;
        inst_addr = 32'hBFC0_0010;
        step();
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if ({bus_req, bus_addr, inst_done} !== {1'b1, 32'hBFC0_0010, 1'b0}) $display("FAIL delay_addr_hold%0d: got req=%b addr=%h done=%b required 1 bfc00010 0", i, bus_req, bus_addr, inst_done);
            else pass_cnt++;
            if (i == 2) bus_addr_ok = 1'b1;
            step();
        end
        bus_addr_ok = 1'b0;
        total_cnt++;
        if ({bus_req, inst_done} !== 2'b00) $display("FAIL delay_data_wait: got req=%b done=%b required 0 0", bus_req, inst_done);
        else pass_cnt++;
        step();
        total_cnt++;
        if (inst_done !== 1'b0) $display("FAIL delay_no_early_done: got %b required 0", inst_done);
        else pass_cnt++;
        bus_data_ok = 1'b1;
        bus_rdata   = 32'h1234_5678;
        step();
        bus_data_ok = 1'b0;
        total_cnt++;
        if ({inst_done, inst_rdata} !== {1'b1, 32'h1234_5678}) $display("FAIL delay_done: got done=%b rdata=%h required 1 12345678", inst_done, inst_rdata);
        else pass_cnt++;
        clear_inputs();
        $display("test_delayed_slave: stretched handshake checked");
    endtask

    task automatic test_reset_in_data;
        do_reset();
        data_req  = 1'b1;
        data_addr = 32'h8000_0040;
        data_be   = 4'hF;
        step();
        bus_addr_ok = 1'b1;
        step();
        bus_addr_ok = 1'b0;
        data_req    = 1'b0;
        rst         = 1'b1;
        step();
        rst = 1'b0;
        total_cnt++;
        if ({bus_req, bus_wr, bus_be, bus_addr, bus_wdata, inst_done, data_done, data_rdata} !== '0) $display("FAIL rst_in_data_outputs: got req=%b addr=%h ddone=%b rdata=%h required all 0", bus_req, bus_addr, data_done, data_rdata);
        else pass_cnt++;
        bus_data_ok = 1'b1;
        bus_rdata   = 32'hCAFE_F00D;
        for (int i = 0; i < 3; i++) begin
            step();
            total_cnt++;
            if ({inst_done, data_done, data_rdata} !== {2'b00, 32'h0}) $display("FAIL rst_late_data_ok%0d: got idone=%b ddone=%b rdata=%h required 0 0 0", i, inst_done, data_done, data_rdata);
            else pass_cnt++;
        end
        clear_inputs();
        $display("test_reset_in_data: abandoned transaction checked");
    endtask

    task automatic test_starve;
        int  k;
        bit  got_inst;
        bit  exp_inst;
        do_reset();
        inst_req    = 1'b1;
        inst_addr   = 32'hBFC0_0000;
        data_req    = 1'b1;
        data_wr     = 1'b0;
        data_be     = 4'hF;
        data_addr   = 32'h8000_0000;
        bus_addr_ok = 1'b1;
        bus_data_ok = 1'b1;
        k = 0;
        for (int cyc = 0; cyc < 40 && k < 6; cyc++) begin
            step();
            if (bus_req === 1'b1) begin
                got_inst = (bus_addr == 32'hBFC0_0000);
                exp_inst = GUARD && (k == LIMIT);
                total_cnt++;
                if (got_inst !== exp_inst) $display("FAIL starve_grant%0d: got %s required %s", k, got_inst ? "I" : "D", exp_inst ? "I" : "D");
                else pass_cnt++;
                k++;
            end
        end
        total_cnt++;
        if (k != 6) $display("FAIL starve_grant_count: got %0d grants required 6", k);
        else pass_cnt++;
        clear_inputs();
        $display("test_starve: grant order with both requests held checked");
    endtask

    task automatic test_back_to_back;
        int last_done;
        int gaps;
        do_reset();
        inst_req    = 1'b1;
        inst_addr   = 32'hBFC0_0100;
        bus_addr_ok = 1'b1;
        bus_data_ok = 1'b1;
        last_done   = -1;
        gaps        = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            step();
            if (bus_req === 1'b1 && last_done >= 0) begin
                total_cnt++;
                if (cyc - last_done != 2) $display("FAIL b2b_gap: got %0d cycles done->req required 2", cyc - last_done);
                else pass_cnt++;
                gaps++;
                last_done = -1;
            end
            if (inst_done === 1'b1) last_done = cyc;
        end
        total_cnt++;
        if (gaps < 3) $display("FAIL b2b_count: got %0d gaps required >=3", gaps);
        else pass_cnt++;
        clear_inputs();
        $display("test_back_to_back: %0d fetch gaps checked", gaps);
    endtask

    task automatic test_random;
        int            ph;
        int            ph_next;
        int            streak;
        int            ntx;
        bit            own_data;
        bit            fetch_wins;
        bit            busy;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        logic [DW-1:0] e_rdata;
        logic [DW-1:0] got_rdata;
        logic          e_wr;
        logic [BW-1:0] e_be;
        do_reset();
        ph = 0; streak = 0; ntx = 0; own_data = 1'b0;
        e_addr = '0; e_wdata = '0; e_rdata = '0; e_wr = 1'b0; e_be = '0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            // completed requester drops its request when done is seen
            if (ph == 3) begin
                if (own_data) data_req = 1'b0;
                else inst_req = 1'b0;
            end
            if (!inst_req && $urandom_range(0, 2) == 0) begin
                inst_req  = 1'b1;
                inst_addr = $urandom() & 32'hFFFF_FFFC;
            end
            if (!data_req && $urandom_range(0, 2) == 0) begin
                data_req   = 1'b1;
                data_wr    = 1'($urandom_range(0, 1));
                data_be    = 4'($urandom_range(1, 15));
                data_addr  = $urandom();
                data_wdata = $urandom();
            end else if (data_req && own_data && (ph == 1 || ph == 2)) begin
                // latched transaction must not follow later changes on the port
                data_addr  = $urandom();
                data_wdata = $urandom();
                data_wr    = 1'($urandom_range(0, 1));
                data_be    = 4'($urandom_range(0, 15));
            end
            bus_addr_ok = 1'($urandom_range(0, 1));
            bus_data_ok = 1'($urandom_range(0, 1));
            bus_rdata   = $urandom();

            ph_next = ph;
            case (ph)
                0: if (inst_req || data_req) begin
                    fetch_wins = inst_req && (!data_req || (GUARD && streak == LIMIT));
                    own_data   = !fetch_wins;
                    if (fetch_wins) begin
                        e_addr = inst_addr; e_wr = 1'b0; e_be = '1; e_wdata = '0;
                        streak = 0;
                    end else begin
                        e_addr = data_addr; e_wr = data_wr; e_be = data_be; e_wdata = data_wdata;
                        streak = inst_req ? ((streak < LIMIT) ? streak + 1 : LIMIT) : 0;
                    end
                    ph_next = 1;
                    ntx++;
                end
                1: if (bus_addr_ok) begin
                    if (bus_data_ok) begin
                        e_rdata = bus_rdata;
                        ph_next = 3;
                    end else begin
                        ph_next = 2;
                    end
                end
                2: if (bus_data_ok) begin
                    e_rdata = bus_rdata;
                    ph_next = 3;
                end
                default: ph_next = 0;
            endcase
            step();
            ph   = ph_next;
            busy = (ph == 1 || ph == 2);

            total_cnt++;
            if (bus_req !== (ph == 1)) $display("FAIL rand_bus_req c%0d: got %b required %b", cyc, bus_req, ph == 1);
            else pass_cnt++;
            total_cnt++;
            if ({inst_done, data_done} !== {(ph == 3) && !own_data, (ph == 3) && own_data}) $display("FAIL rand_done c%0d: got idone=%b ddone=%b required %b %b", cyc, inst_done, data_done, (ph == 3) && !own_data, (ph == 3) && own_data);
            else pass_cnt++;
            total_cnt++;
            if ({bus_addr, bus_wr, bus_be} !== (busy ? {e_addr, e_wr, e_be} : '0)) $display("FAIL rand_bus_fields c%0d: got addr=%h wr=%b be=%h required addr=%h wr=%b be=%h", cyc, bus_addr, bus_wr, bus_be, busy ? e_addr : '0, busy ? e_wr : 1'b0, busy ? e_be : '0);
            else pass_cnt++;
            if (!busy || own_data) begin
                total_cnt++;
                if (bus_wdata !== (busy ? e_wdata : '0)) $display("FAIL rand_bus_wdata c%0d: got %h required %h", cyc, bus_wdata, busy ? e_wdata : '0);
                else pass_cnt++;
            end
            if (ph == 3) begin
                got_rdata = own_data ? data_rdata : inst_rdata;
                total_cnt++;
                if (got_rdata !== e_rdata) $display("FAIL rand_rdata c%0d: got %h required %h", cyc, got_rdata, e_rdata);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (ntx < 20) $display("FAIL rand_tx_count: got %0d transactions required >=20", ntx);
        else pass_cnt++;
        clear_inputs();
        $display("test_random: %0d randomized transactions checked", ntx);
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_fetch_alone();
        test_simultaneous();
        test_delayed_slave();
        test_reset_in_data();
        test_starve();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
